// File: rtl/rmt_recovery_sequencer_pkg.sv
// Shared types and constants for the RMT bulk-write sequencer.
package rmt_recovery_sequencer_pkg;

    // Width of a counter that indexes n items, never narrower than 1 bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_RECOVER = 2'd2,
        ST_DRAIN   = 2'd3
    } RmtSeqState;

    localparam int RMT_SEQ_LREG_NUM       = 64;
    localparam int RMT_SEQ_COMMIT_WIDTH   = 2;
    localparam int RMT_SEQ_PREG_BITS      = 7;
    localparam int RMT_SEQ_IQ_PTR_BITS    = 4;
    localparam int RMT_SEQ_FREE_LIST_BASE = 64;

    localparam int RMT_SEQ_GROUP_NUM      = RMT_SEQ_LREG_NUM / RMT_SEQ_COMMIT_WIDTH;
    localparam int RMT_SEQ_GROUP_BIT_SIZE = clog2_min1(RMT_SEQ_GROUP_NUM);

endpackage

// File: rtl/rmt_recovery_sequencer_read_pipe.sv
// One-entry pipeline between a retirement-RMT read (or an INIT issue) and
// the RMT write it produces one cycle later.
module rmt_recovery_sequencer_read_pipe
    import rmt_recovery_sequencer_pkg::*;
#(
    parameter int GRP_W = RMT_SEQ_GROUP_BIT_SIZE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid_i,
    input  logic [GRP_W-1:0] issue_grp_i,
    input  logic             issue_init_i,
    input  logic             issue_last_i,
    output logic             valid_o,
    output logic [GRP_W-1:0] grp_o,
    output logic             init_o,
    output logic             last_o
);

    logic             valid_q;
    logic [GRP_W-1:0] grp_q;
    logic             init_q;
    logic             last_q;

    // Capture the issued group every cycle; valid marks whether it writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            grp_q   <= '0;
            init_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= issue_valid_i;
            grp_q   <= issue_grp_i;
            init_q  <= issue_init_i;
            last_q  <= issue_last_i;
        end
    end

    assign valid_o = valid_q;
    assign grp_o   = grp_q;
    assign init_o  = init_q;
    assign last_o  = last_q;

endmodule

// File: rtl/rmt_recovery_sequencer.sv
// Owns the speculative RMT write ports during the power-on initialization
// walk and the post-flush copy from the retirement RMT.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_INIT    | writing entry k <- phy k+FREE_LIST_BASE, one group per cycle
// ST_IDLE    | commit path owns the RMT, rename runs
// ST_RECOVER | reading retirement RMT group grp, writing the previous group
// ST_DRAIN   | last group's read data is being written
module rmt_recovery_sequencer
    import rmt_recovery_sequencer_pkg::*;
#(
    parameter int LREG_NUM       = RMT_SEQ_LREG_NUM,
    parameter int WRITE_NUM      = RMT_SEQ_COMMIT_WIDTH,
    parameter int PREG_BITS      = RMT_SEQ_PREG_BITS,
    parameter int IQ_PTR_BITS    = RMT_SEQ_IQ_PTR_BITS,
    parameter int FREE_LIST_BASE = RMT_SEQ_FREE_LIST_BASE
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        recoverReq_i,
    output logic [$clog2(LREG_NUM)-1:0] retRA_o     [WRITE_NUM],
    input  logic [PREG_BITS-1:0]        retRV_i     [WRITE_NUM],
    output logic                        seqWE_o     [WRITE_NUM],
    output logic [$clog2(LREG_NUM)-1:0] seqWA_o     [WRITE_NUM],
    output logic [PREG_BITS-1:0]        seqWPhy_o   [WRITE_NUM],
    output logic [IQ_PTR_BITS-1:0]      seqWIqPtr_o [WRITE_NUM],
    output logic                        seqOwnsPort_o,
    output logic                        renameStall_o,
    output logic                        done_o
);

    localparam int G      = LREG_NUM / WRITE_NUM;
    localparam int GRP_W  = clog2_min1(G);
    localparam int ADDR_W = $clog2(LREG_NUM);

    if (LREG_NUM % WRITE_NUM != 0) begin : g_bad_group
        $error("LREG_NUM must be a multiple of WRITE_NUM");
    end
    if (LREG_NUM + FREE_LIST_BASE > (1 << PREG_BITS)) begin : g_bad_phy
        $error("LREG_NUM + FREE_LIST_BASE exceeds the physical register space");
    end

    function automatic logic [ADDR_W-1:0] entry_of(input logic [GRP_W-1:0] g, input int lane);
        return ADDR_W'(g) * ADDR_W'(WRITE_NUM) + ADDR_W'(lane);
    endfunction

    RmtSeqState       state_q, state_d;
    logic [GRP_W-1:0] grp_q, grp_d;
    logic             pending_q, pending_d;
    logic             done_q, done_d;
    logic             stall_q, stall_d;
    logic             ra_valid_q, ra_valid_d;
    logic [GRP_W-1:0] ra_grp_q;

    logic             grp_last;
    logic             restart;
    logic             iss_valid;
    logic             iss_init;
    logic             iss_last;

    logic             pipe_valid;
    logic [GRP_W-1:0] pipe_grp;
    logic             pipe_init;
    logic             pipe_last;

    assign grp_last = (grp_q == GRP_W'(G - 1));

    // Next-state, group counter and issue decode for the write pipeline.
    always_comb begin
        state_d   = state_q;
        grp_d     = grp_q;
        pending_d = pending_q;
        iss_valid = 1'b0;
        iss_init  = 1'b0;
        iss_last  = 1'b0;
        restart   = 1'b0;
        case (state_q)
            ST_INIT: begin
                iss_valid = 1'b1;
                iss_init  = 1'b1;
                iss_last  = grp_last;
                if (recoverReq_i) begin
                    pending_d = 1'b1;
                end
                if (grp_last) begin
                    grp_d     = '0;
                    pending_d = 1'b0;
                    state_d   = (pending_q || recoverReq_i) ? ST_RECOVER : ST_IDLE;
                end else begin
                    grp_d = grp_q + GRP_W'(1);
                end
            end
            ST_IDLE: begin
                if (recoverReq_i) begin
                    state_d = ST_RECOVER;
                    grp_d   = '0;
                end
            end
            ST_RECOVER: begin
                if (recoverReq_i) begin
                    // The read issued this cycle is abandoned: no pipe entry.
                    restart = 1'b1;
                    grp_d   = '0;
                end else begin
                    iss_valid = 1'b1;
                    iss_last  = grp_last;
                    if (grp_last) begin
                        grp_d   = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        grp_d = grp_q + GRP_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (recoverReq_i) begin
                    restart = 1'b1;
                    grp_d   = '0;
                    state_d = ST_RECOVER;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_INIT;
                grp_d   = '0;
            end
        endcase

        // A restarted recovery swallows the done of the walk it replaces;
        // the INIT walk's done is kept since INIT itself completed.
        done_d     = pipe_valid && pipe_last && !(restart && !pipe_init);
        stall_d    = (state_d != ST_IDLE) || iss_valid;
        ra_valid_d = (state_d == ST_RECOVER);
    end

    // Control state and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            grp_q      <= '0;
            pending_q  <= 1'b0;
            done_q     <= 1'b0;
            stall_q    <= 1'b1;
            ra_valid_q <= 1'b0;
            ra_grp_q   <= '0;
        end else begin
            state_q    <= state_d;
            grp_q      <= grp_d;
            pending_q  <= pending_d;
            done_q     <= done_d;
            stall_q    <= stall_d;
            ra_valid_q <= ra_valid_d;
            ra_grp_q   <= grp_d;
        end
    end

    rmt_recovery_sequencer_read_pipe #(
        .GRP_W (GRP_W)
    ) u_read_pipe (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_valid_i (iss_valid),
        .issue_grp_i   (grp_q),
        .issue_init_i  (iss_init),
        .issue_last_i  (iss_last),
        .valid_o       (pipe_valid),
        .grp_o         (pipe_grp),
        .init_o        (pipe_init),
        .last_o        (pipe_last)
    );

    for (genvar i = 0; i < WRITE_NUM; i++) begin : g_lane
        assign retRA_o[i]     = ra_valid_q ? entry_of(ra_grp_q, i) : '0;
        assign seqWE_o[i]     = pipe_valid;
        assign seqWA_o[i]     = pipe_valid ? entry_of(pipe_grp, i) : '0;
        assign seqWPhy_o[i]   = !pipe_valid ? '0 :
                                pipe_init   ? PREG_BITS'(entry_of(pipe_grp, i)) + PREG_BITS'(FREE_LIST_BASE) :
                                              retRV_i[i];
        assign seqWIqPtr_o[i] = '0;
    end

    assign seqOwnsPort_o = stall_q;
    assign renameStall_o = stall_q;
    assign done_o        = done_q;

endmodule
